// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, default PC step and reset
// address, and the alignment-mask helper used on branch targets.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        HALTED  = 2'd2
    } fetchState_t;

    localparam int          DEFAULT_INSTR_BYTES = 4;
    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0;

    // Keeps every address bit above the instruction-size boundary.
    function automatic logic [63:0] alignMask(input int instrBytes);
        return ~(64'(instrBytes) - 64'd1);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_pc_reg.sv
// Program counter register with sequential/branch next-PC selection, target alignment
// and a one-entry slot that holds a PC update arriving while a fetch is in flight.
module fetch_pc_reg
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                INSTR_BYTES = DEFAULT_INSTR_BYTES,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_writeNow,
    input  logic              i_writeDefer,
    input  logic              i_applyPending,
    input  logic              i_clearPending,
    input  logic              i_branchTaken,
    input  logic [ADDR_W-1:0] i_branchTarget,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_updated,
    output logic              o_pending
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_updated;
    logic              r_pendValid;
    logic              r_pendBranch;
    logic [ADDR_W-1:0] r_pendTarget;

    logic [ADDR_W-1:0] w_mask;
    logic [ADDR_W-1:0] w_seqPc;
    logic [ADDR_W-1:0] w_nowPc;
    logic [ADDR_W-1:0] w_pendPc;

    assign w_mask   = ADDR_W'(alignMask(INSTR_BYTES));
    assign w_seqPc  = r_pc + ADDR_W'(INSTR_BYTES);
    assign w_nowPc  = i_branchTaken ? (i_branchTarget & w_mask) : w_seqPc;
    assign w_pendPc = r_pendBranch ? (r_pendTarget & w_mask) : w_seqPc;

    // A direct write in IDLE is newer than anything pending, so it wins and drops the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_updated    <= 1'b0;
            r_pendValid  <= 1'b0;
            r_pendBranch <= 1'b0;
            r_pendTarget <= '0;
        end else begin
            r_updated <= 1'b0;
            if (i_clearPending) begin
                r_pendValid <= 1'b0;
            end else if (i_writeNow) begin
                r_pc        <= w_nowPc;
                r_updated   <= 1'b1;
                r_pendValid <= 1'b0;
            end else if (i_applyPending && r_pendValid) begin
                r_pc        <= w_pendPc;
                r_updated   <= 1'b1;
                r_pendValid <= 1'b0;
            end else if (i_writeDefer) begin
                r_pendValid  <= 1'b1;
                r_pendBranch <= i_branchTaken;
                r_pendTarget <= i_branchTarget;
            end
        end
    end

    assign o_pc      = r_pc;
    assign o_updated = r_updated;
    assign o_pending = r_pendValid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: runs the instruction-memory read handshake with a timeout, hands the word
// to decode, and forwards PC updates from ControlUnit to the PC register.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                INSTR_BYTES    = DEFAULT_INSTR_BYTES,
    parameter logic [ADDR_W-1:0] RESET_PC       = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              startInstructionFetch,
    input  logic              programCounterWrite,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchTarget,
    input  logic              haltExecution,
    output logic              imemReq,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic              imemReady,
    input  logic [DATA_W-1:0] imemData,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] instructionPc,
    output logic              instructionFetched,
    output logic              programCounterUpdated,
    output logic [ADDR_W-1:0] pc,
    output logic              fetchError
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    fetchState_t      r_state;
    logic [CNT_W-1:0] r_waitCount;

    logic w_writeNow;
    logic w_writeDefer;
    logic w_applyPending;
    logic w_clearPending;
    logic w_pending;
    logic w_pcBusy;
    logic w_timeout;

    // Halt outranks any PC update; a PC update in IDLE (new or pending) swallows a start.
    assign w_writeNow     = (r_state == IDLE) && programCounterWrite && !haltExecution;
    assign w_writeDefer   = (r_state == REQUEST) && programCounterWrite && !haltExecution;
    assign w_applyPending = (r_state == IDLE) && !haltExecution;
    assign w_clearPending = haltExecution || (r_state == HALTED);
    assign w_pcBusy       = w_writeNow || ((r_state == IDLE) && w_pending);
    assign w_timeout      = (TIMEOUT_CYCLES != 0) &&
                            (r_waitCount == CNT_W'(TIMEOUT_CYCLES - 1));

    fetch_pc_reg #(
        .ADDR_W      (ADDR_W),
        .INSTR_BYTES (INSTR_BYTES),
        .RESET_PC    (RESET_PC)
    ) u_pcReg (
        .clk            (clk),
        .rst            (rst),
        .i_writeNow     (w_writeNow),
        .i_writeDefer   (w_writeDefer),
        .i_applyPending (w_applyPending),
        .i_clearPending (w_clearPending),
        .i_branchTaken  (branchTaken),
        .i_branchTarget (branchTarget),
        .o_pc           (pc),
        .o_updated      (programCounterUpdated),
        .o_pending      (w_pending)
    );

    assign imemAddr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= IDLE;
            r_waitCount        <= '0;
            imemReq            <= 1'b0;
            instruction        <= '0;
            instructionPc      <= '0;
            instructionFetched <= 1'b0;
            fetchError         <= 1'b0;
        end else begin
            instructionFetched <= 1'b0;
            if (haltExecution || (r_state == HALTED)) begin
                r_state <= HALTED;
                imemReq <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (startInstructionFetch && !w_pcBusy) begin
                            r_state     <= REQUEST;
                            imemReq     <= 1'b1;
                            r_waitCount <= '0;
                        end
                    end
                    REQUEST: begin
                        if (imemReady) begin
                            instruction        <= imemData;
                            instructionPc      <= pc;
                            instructionFetched <= 1'b1;
                            imemReq            <= 1'b0;
                            r_state            <= IDLE;
                        end else if (w_timeout) begin
                            fetchError <= 1'b1;
                            imemReq    <= 1'b0;
                            r_state    <= IDLE;
                        end else begin
                            r_waitCount <= r_waitCount + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= HALTED;
                        imemReq <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit: handshake latency, PC updates,
// timeout, deferred branch during a fetch, halt, wrap-around and start/write collision.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;
    logic        startInstructionFetch;
    logic        programCounterWrite;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        haltExecution;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemData;
    logic [31:0] instruction;
    logic [31:0] instructionPc;
    logic        instructionFetched;
    logic        programCounterUpdated;
    logic [31:0] pc;
    logic        fetchError;

    int checks   = 0;
    int failures = 0;
    logic sawFetch;

    instruction_fetch_unit dut (
        .clk                   (clk),
        .rst                   (rst),
        .startInstructionFetch (startInstructionFetch),
        .programCounterWrite   (programCounterWrite),
        .branchTaken           (branchTaken),
        .branchTarget          (branchTarget),
        .haltExecution         (haltExecution),
        .imemReq               (imemReq),
        .imemAddr              (imemAddr),
        .imemReady             (imemReady),
        .imemData              (imemData),
        .instruction           (instruction),
        .instructionPc         (instructionPc),
        .instructionFetched    (instructionFetched),
        .programCounterUpdated (programCounterUpdated),
        .pc                    (pc),
        .fetchError            (fetchError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one rising edge and settle so outputs can be sampled and inputs re-driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic pcWrite,
                                 input logic taken, input logic [31:0] target);
        startInstructionFetch = start;
        programCounterWrite   = pcWrite;
        branchTaken           = taken;
        branchTarget          = target;
        tick();
        startInstructionFetch = 1'b0;
        programCounterWrite   = 1'b0;
        branchTaken           = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst                   = 1'b1;
        startInstructionFetch = 1'b0;
        programCounterWrite   = 1'b0;
        branchTaken           = 1'b0;
        branchTarget          = 32'h0;
        haltExecution         = 1'b0;
        imemReady             = 1'b0;
        imemData              = 32'h0;
        doReset();

        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_req", imemReq, 0);
        checkOutput("rst_fetched", instructionFetched, 0);
        checkOutput("rst_instr", instruction, 32'h0);
        checkOutput("rst_err", fetchError, 0);
        checkOutput("rst_upd", programCounterUpdated, 0);

        // 1: best-case fetch
        imemReady = 1'b1;
        imemData  = 32'hDEADBEEF;
        applyStimulus(1, 0, 0, 0);
        checkOutput("t1_req", imemReq, 1);
        checkOutput("t1_addr", imemAddr, 32'h0);
        checkOutput("t1_notyet", instructionFetched, 0);
        tick();
        checkOutput("t1_fetched", instructionFetched, 1);
        checkOutput("t1_instr", instruction, 32'hDEADBEEF);
        checkOutput("t1_ipc", instructionPc, 32'h0);
        checkOutput("t1_reqdrop", imemReq, 0);
        tick();
        checkOutput("t1_pulse1", instructionFetched, 0);
        imemReady = 1'b0;

        // 2: sequential then aligned branch
        applyStimulus(0, 1, 0, 0);
        checkOutput("t2_pc4", pc, 32'h4);
        checkOutput("t2_upd1", programCounterUpdated, 1);
        tick();
        checkOutput("t2_upd1_end", programCounterUpdated, 0);
        applyStimulus(0, 1, 1, 32'h103);
        checkOutput("t2_pc100", pc, 32'h100);
        checkOutput("t2_upd2", programCounterUpdated, 1);
        tick();
        checkOutput("t2_upd2_end", programCounterUpdated, 0);

        // 3: timeout after 16 REQUEST cycles without ready
        sawFetch = 1'b0;
        applyStimulus(1, 0, 0, 0);
        checkOutput("t3_req", imemReq, 1);
        for (int i = 0; i < 15; i++) begin
            tick();
            sawFetch |= instructionFetched;
        end
        checkOutput("t3_stillreq", imemReq, 1);
        checkOutput("t3_noerr_yet", fetchError, 0);
        tick();
        sawFetch |= instructionFetched;
        checkOutput("t3_err", fetchError, 1);
        checkOutput("t3_reqdrop", imemReq, 0);
        tick();
        sawFetch |= instructionFetched;
        checkOutput("t3_nofetch", sawFetch, 0);
        imemReady = 1'b1;
        imemData  = 32'h12345678;
        applyStimulus(1, 0, 0, 0);
        tick();
        checkOutput("t3_refetch", instructionFetched, 1);
        checkOutput("t3_instr", instruction, 32'h12345678);
        checkOutput("t3_ipc", instructionPc, 32'h100);
        checkOutput("t3_errsticky", fetchError, 1);
        imemReady = 1'b0;

        // 4: branch arrives mid-request, applied after return to IDLE
        doReset();
        checkOutput("t4_errclr", fetchError, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t4_pc8", pc, 32'h8);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t4_req", imemReq, 1);
        applyStimulus(0, 1, 1, 32'h40);
        checkOutput("t4_addr_a", imemAddr, 32'h8);
        checkOutput("t4_noupd", programCounterUpdated, 0);
        tick();
        checkOutput("t4_addr_b", imemAddr, 32'h8);
        imemReady = 1'b1;
        imemData  = 32'hCAFEF00D;
        tick();
        imemReady = 1'b0;
        checkOutput("t4_fetched", instructionFetched, 1);
        checkOutput("t4_instr", instruction, 32'hCAFEF00D);
        checkOutput("t4_ipc", instructionPc, 32'h8);
        checkOutput("t4_pc_hold", pc, 32'h8);
        tick();
        checkOutput("t4_pc40", pc, 32'h40);
        checkOutput("t4_upd", programCounterUpdated, 1);

        // 5: halt aborts a request; starts and writes ignored until reset
        applyStimulus(1, 0, 0, 0);
        checkOutput("t5_req", imemReq, 1);
        haltExecution = 1'b1;
        imemReady     = 1'b1;
        tick();
        haltExecution = 1'b0;
        checkOutput("t5_reqdrop", imemReq, 0);
        checkOutput("t5_nofetch", instructionFetched, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t5_ign_req", imemReq, 0);
        tick();
        checkOutput("t5_ign_fetch", instructionFetched, 0);
        applyStimulus(0, 1, 1, 32'h200);
        checkOutput("t5_ign_pc", pc, 32'h40);
        checkOutput("t5_ign_upd", programCounterUpdated, 0);
        doReset();
        checkOutput("t5_rst_pc", pc, 32'h0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("t5_idle_req", imemReq, 1);
        tick();
        checkOutput("t5_idle_fetch", instructionFetched, 1);
        imemReady = 1'b0;

        // 6: wrap-around and start colliding with a PC write
        applyStimulus(0, 1, 1, 32'hFFFFFFFF);
        checkOutput("t6_pcmax", pc, 32'hFFFFFFFC);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t6_wrap", pc, 32'h0);
        tick();
        applyStimulus(1, 1, 0, 0);
        checkOutput("t6_pc4", pc, 32'h4);
        checkOutput("t6_upd", programCounterUpdated, 1);
        checkOutput("t6_noreq", imemReq, 0);
        tick();
        checkOutput("t6_noreq2", imemReq, 0);
        checkOutput("t6_nofetch", instructionFetched, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
